// File: rtl/accel_pkg.sv
// Shared types for the accelerator datapath blocks.
// Holds the accumulator bank's row-state encoding.
package accel_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } acc_state_e;

endpackage

// File: rtl/sat_adder.sv
// Signed ACC_W + DATA_W adder with clamp to the ACC_W range.
// Also used by the vector unit.
module sat_adder #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit: the top two bits disagree exactly when the result left range.
    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] wide);
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamp = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            clamp = wide[ACC_W-1:0];
        end
    endfunction

    logic signed [ACC_W:0] wide_s;

    assign wide_s = (ACC_W+1)'(acc) + (ACC_W+1)'(data);
    assign sum    = clamp(wide_s);
    assign ovf    = wide_s[ACC_W] != wide_s[ACC_W-1];

endmodule

// File: rtl/accumulator_bank.sv
// Column-output accumulator: sums PASSES partial-product passes over a
// DEPTH-entry row, then drains the row over a valid/ready interface.
module accumulator_bank
    import accel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int DEPTH  = 4,
    parameter int PASSES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_W-1:0]     in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_W-1:0]      out_data,
    output logic [$clog2(DEPTH)-1:0]     out_index,
    output logic                         full,
    output logic                         sat_flag
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    acc_state_e               state_r, state_nxt_s;
    logic [IDX_W-1:0]         wr_idx_r, wr_idx_nxt_s;
    logic [IDX_W-1:0]         rd_idx_r, rd_idx_nxt_s;
    logic [PASS_W-1:0]        pass_r, pass_nxt_s;
    logic                     sat_r, sat_nxt_s;
    logic signed [ACC_W-1:0]  out_data_r, out_data_nxt_s;
    logic signed [ACC_W-1:0]  mem_r [DEPTH];
    logic signed [ACC_W-1:0]  sum_s, wr_val_s;
    logic                     ovf_s, accept_s, mem_we_s, last_wr_s, last_pass_s;

    sat_adder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_sat_adder (
        .acc  (mem_r[wr_idx_r]),
        .data (in_data),
        .sum  (sum_s),
        .ovf  (ovf_s)
    );

    assign accept_s    = in_valid && (state_r == FILL);
    assign last_wr_s   = wr_idx_r == IDX_W'(DEPTH-1);
    assign last_pass_s = pass_r == PASS_W'(PASSES-1);
    // Pass 0 overwrites, so stale contents from the previous row never leak in.
    assign wr_val_s    = (pass_r == '0) ? ACC_W'(in_data) : sum_s;

    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == DRAIN);
    assign full      = (state_r == DRAIN);
    assign out_data  = out_data_r;
    assign out_index = rd_idx_r;
    assign sat_flag  = sat_r;

    // Next-state, index, flag and drain-data decode.
    always_comb begin
        state_nxt_s    = state_r;
        wr_idx_nxt_s   = wr_idx_r;
        rd_idx_nxt_s   = rd_idx_r;
        pass_nxt_s     = pass_r;
        sat_nxt_s      = sat_r;
        out_data_nxt_s = out_data_r;
        mem_we_s       = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    mem_we_s  = 1'b1;
                    sat_nxt_s = sat_r | ((pass_r != '0) && ovf_s);
                    if (last_wr_s) begin
                        wr_idx_nxt_s = '0;
                        if (last_pass_s) begin
                            pass_nxt_s     = '0;
                            state_nxt_s    = DRAIN;
                            // Entry 0 is already final: DEPTH >= 2.
                            out_data_nxt_s = mem_r[0];
                        end else begin
                            pass_nxt_s = pass_r + PASS_W'(1);
                        end
                    end else begin
                        wr_idx_nxt_s = wr_idx_r + IDX_W'(1);
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_r == IDX_W'(DEPTH-1)) begin
                        rd_idx_nxt_s   = '0;
                        state_nxt_s    = FILL;
                        sat_nxt_s      = 1'b0;
                        out_data_nxt_s = '0;
                    end else begin
                        rd_idx_nxt_s   = rd_idx_r + IDX_W'(1);
                        out_data_nxt_s = mem_r[rd_idx_r + IDX_W'(1)];
                    end
                end else begin
                    rd_idx_nxt_s = rd_idx_r;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State, index and output registers; clear mirrors reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= FILL;
            wr_idx_r   <= '0;
            rd_idx_r   <= '0;
            pass_r     <= '0;
            sat_r      <= 1'b0;
            out_data_r <= '0;
        end else if (clear) begin
            state_r    <= FILL;
            wr_idx_r   <= '0;
            rd_idx_r   <= '0;
            pass_r     <= '0;
            sat_r      <= 1'b0;
            out_data_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            rd_idx_r   <= rd_idx_nxt_s;
            pass_r     <= pass_nxt_s;
            sat_r      <= sat_nxt_s;
            out_data_r <= out_data_nxt_s;
        end
    end

    // Row storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (mem_we_s) begin
            mem_r[wr_idx_r] <= wr_val_s;
        end
    end

endmodule
